// File: rtl/board_io_pkg.sv
// Shared types, defaults and helpers for the board I/O front-end.
package board_io_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_STEP
    } core_state_t;

    // 10 ms of stability at a 50 MHz board clock
    localparam int DEF_DEBOUNCE_CYC = 500000;
    localparam int DEF_CLK_DIV      = 2;

    // Counter width able to index 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/board_io_if.sv
// Board-side bundle: raw keys/switches in, debounced levels and core controls out.
interface board_io_if #(
    parameter int N_KEY = 4,
    parameter int N_SW  = 10
);
    logic [N_KEY-1:0] i_key;
    logic [N_SW-1:0]  i_sw;
    logic             i_step_mode;
    logic [N_KEY-1:0] o_key_level;
    logic [N_KEY-1:0] o_key_press;
    logic [N_SW-1:0]  o_sw;
    logic             o_core_en;
    logic             o_core_rst;
    logic             o_mode_step;

    // Board / stimulus side
    modport master (
        output i_key, i_sw, i_step_mode,
        input  o_key_level, o_key_press, o_sw, o_core_en, o_core_rst, o_mode_step
    );

    // Controller side
    modport slave (
        input  i_key, i_sw, i_step_mode,
        output o_key_level, o_key_press, o_sw, o_core_en, o_core_rst, o_mode_step
    );
endinterface

// File: rtl/debounce_ch.sv
// One input channel: multi-flop synchroniser, stability counter, rising-edge pulse.
module debounce_ch
    import board_io_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = clog2_min1(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   prev_q;
    logic                   rise_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Accept the synced value only once it has differed for DEBOUNCE_CYC cycles
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
        end else if (synced == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= synced;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered one-cycle pulse on each accepted 0->1 transition
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
        end else begin
            prev_q <= stable_q;
            rise_q <= stable_q & ~prev_q;
        end
    end

    assign o_level = stable_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board front-end: debounced keys/switches, core clock-enable (run or single-step)
// and a stretched core reset, all on the single system clock.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int N_KEY        = 4,
    parameter int N_SW         = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int STEP_KEY     = 0,
    parameter int RST_HOLD     = 16
) (
    input  logic  i_clk,
    input  logic  i_reset,
    board_io_if.slave bus
);

    localparam int HOLD_W = clog2_min1(RST_HOLD);
    localparam int DIV_W  = clog2_min1(CLK_DIV);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_press;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_rise_unused;
    logic             mode_step;
    logic             mode_rise_unused;

    core_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              step_req_q;
    logic              core_en;
    logic              core_rst;

    // Keys are active-low on the board; invert so the channel sees 1 = pressed
    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .RESET_VAL   (1'b0)
        ) u_key (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_raw  (~bus.i_key[k]),
            .o_level(key_level[k]),
            .o_rise (key_press[k])
        );
    end

    for (genvar s = 0; s < N_SW; s++) begin : g_sw
        debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .RESET_VAL   (1'b0)
        ) u_sw (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_raw  (bus.i_sw[s]),
            .o_level(sw_level[s]),
            .o_rise (sw_rise_unused[s])
        );
    end

    debounce_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .RESET_VAL   (1'b0)
    ) u_mode (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_raw  (bus.i_step_mode),
        .o_level(mode_step),
        .o_rise (mode_rise_unused)
    );

    // State, stretch counter, divider and the delayed step request
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_HOLD;
            hold_q     <= '0;
            div_q      <= '0;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            step_req_q <= key_press[STEP_KEY];
        end
    end

    // Next state and core controls; a mode change costs one silent cycle
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        div_d    = div_q;
        core_en  = 1'b0;
        core_rst = 1'b0;
        case (state_q)
            S_HOLD: begin
                core_rst = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = mode_step ? S_STEP : S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                if (mode_step) begin
                    state_d = S_STEP;
                    div_d   = '0;
                end else begin
                    core_en = (div_q == DIV_LAST);
                    div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                end
            end
            S_STEP: begin
                if (!mode_step) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end else begin
                    core_en = step_req_q;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    assign bus.o_key_level = key_level;
    assign bus.o_key_press = key_press;
    assign bus.o_sw        = sw_level;
    assign bus.o_core_en   = core_en;
    assign bus.o_core_rst  = core_rst;
    assign bus.o_mode_step = mode_step;

endmodule
